// File: rtl/spi_prog_loader_pkg.sv
// Shared definitions for the programming link: mode encoding, frame geometry
// and the loader state type. The driver side imports the same mode constants.
package spi_prog_loader_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LDI  = 2'b01;
    localparam logic [1:0] MODE_LDD  = 2'b10;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    localparam int FRAME_BITS   = 12;
    localparam int DEF_PREAMBLE = 2;
    localparam int DEF_ADDR_W   = 4;
    localparam int DATA_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_COMMIT,
        ST_DRAIN,
        ST_RUN
    } loader_state_e;

    function automatic logic is_load_mode(input logic [1:0] mode);
        return (mode == MODE_LDI) || (mode == MODE_LDD);
    endfunction

endpackage

// File: rtl/spi_prog_loader_shifter.sv
// LSB-first frame deserializer: bit k of the frame lands in word bit k.
// word_next exposes the word including the bit being sampled this cycle.
module spi_frame_shifter
    import spi_prog_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  shift_en_i,
    input  logic                  bit_i,
    output logic [FRAME_BITS-1:0] word_next_o,
    output logic                  last_o,
    output logic                  full_o
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] word_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  take;

    assign full_o = (cnt_q == CNT_W'(FRAME_BITS));
    assign last_o = (cnt_q == CNT_W'(FRAME_BITS - 1));
    assign take   = shift_en_i && !full_o;

    generate
        for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_bit
            assign word_next_o[gi] = (take && (cnt_q == CNT_W'(gi))) ? bit_i : word_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (take) begin
            word_q <= word_next_o;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_prog_loader.sv
// Programming-link receiver: deserializes address/data frames into single-cycle
// write strobes for instruction memory or register file, and gates core run.
module spi_prog_loader
    import spi_prog_loader_pkg::*;
#(
    parameter int PREAMBLE = DEF_PREAMBLE,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mosi_in,
    input  logic [1:0]        mode_in,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              run_out,
    input  logic              halt_in,
    output logic              done_out,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int PRE_W = $clog2(PREAMBLE + 1);
    // The accepting IDLE edge is the first preamble cycle, so PRE counts the rest.
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PREAMBLE - 1);

    loader_state_e     state_q, state_d;
    logic [1:0]        mode_lat_q, mode_lat_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        frame_cnt_q;
    logic              frame_err_q;
    logic              abort;
    logic              commit;

    logic                  sh_shift_en;
    logic                  sh_clear;
    logic [FRAME_BITS-1:0] sh_word_next;
    logic                  sh_last;
    logic                  sh_full;

    assign sh_clear    = (state_q != ST_SHIFT);
    assign sh_shift_en = (state_q == ST_SHIFT) && (mode_in == mode_lat_q) && !sh_full;

    spi_frame_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (sh_clear),
        .shift_en_i  (sh_shift_en),
        .bit_i       (mosi_in),
        .word_next_o (sh_word_next),
        .last_o      (sh_last),
        .full_o      (sh_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_lat_q <= MODE_IDLE;
            pre_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_lat_q <= mode_lat_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        pre_cnt_d  = pre_cnt_q;
        abort      = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_load_mode(mode_in)) begin
                    mode_lat_d = mode_in;
                    pre_cnt_d  = PRE_LOAD;
                    state_d    = (PREAMBLE > 1) ? ST_PRE : ST_SHIFT;
                end else if (mode_in == MODE_RUN) begin
                    state_d = ST_RUN;
                end
            end
            ST_PRE: begin
                if (mode_in != mode_lat_q) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (pre_cnt_q <= PRE_W'(1)) begin
                    state_d = ST_SHIFT;
                end else begin
                    pre_cnt_d = pre_cnt_q - PRE_W'(1);
                end
            end
            ST_SHIFT: begin
                if (mode_in != mode_lat_q) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (sh_last) begin
                    commit  = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (mode_in == MODE_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mode_in != MODE_RUN) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_we  = (state_q == ST_COMMIT) && (mode_lat_q == MODE_LDI);
        dmem_we  = (state_q == ST_COMMIT) && (mode_lat_q == MODE_LDD);
        run_out  = (state_q == ST_RUN) && (mode_in == MODE_RUN) && !halt_in;
        done_out = (state_q == ST_RUN) && (mode_in == MODE_RUN) && halt_in;
    end

    // Address/data and the frame count update on the edge entering COMMIT so they
    // are valid alongside the strobe, then hold until the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (commit) begin
                wr_addr_q   <= sh_word_next[ADDR_W-1:0];
                wr_data_q   <= sh_word_next[ADDR_W +: 8];
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (abort) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_cnt = frame_cnt_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/spi_prog_loader.md
Name: spi_prog_loader

Overview:
- Serial receiver on the tiny-processor side of the FPGA-demo programming link.
- Consumes the driver's mosi/mode stream and deserializes 12-bit load frames, each carrying a 4-bit address and an 8-bit byte.
- Issues single-cycle write strobes to the core's instruction memory or register file, then gates the core's run enable during the run phase.
- Returns a completion flag to the driver when the core halts.

Parameters:
- PREAMBLE, 2, cycles discarded after mode_in leaves 2'b00 before the first data bit is sampled.
- FRAME_BITS, 12, data bits per frame (4 address + 8 data); fixed by the link format.
- ADDR_W, 4, address width of both write ports.

Ports:
- clk  in  1  system clock; all sampling on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mosi_in  in  1  serial data from driver; LSB first.
- mode_in  in  2  00 idle, 01 instruction load, 10 register load, 11 run.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- dmem_we  out  1  one-cycle register-file write strobe.
- wr_addr  out  ADDR_W  write address shared by both ports.
- wr_data  out  8  write data shared by both ports.
- run_out  out  1  core execute enable.
- halt_in  in  1  core reports program end (level).
- done_out  out  1  to driver: core finished the current run.
- frame_err  out  1  sticky: a frame was truncated or mode changed mid-frame.
- frame_cnt  out  8  count of committed frames; wraps 255 -> 0.

Behaviour:
- Reset: all outputs 0; shift register, bit counter and preamble counter 0; state IDLE.
- States: IDLE, PRE, SHIFT, COMMIT, DRAIN, RUN.
- IDLE:
  - mode_in 01/10 -> latch target (imem/dmem), load preamble counter, go to PRE.
  - mode_in 11 -> RUN.
  - mode_in 00 -> stay.
- PRE:
  - Count PREAMBLE rising edges with mode_in equal to the latched mode; mosi_in is ignored.
  - Then go to SHIFT with bit counter 0.
- SHIFT:
  - Each cycle mode_in equals the latched mode: shift mosi_in into bit[cnt], increment cnt.
  - Bits 0-3 form wr_addr; bits 4-11 form wr_data.
  - After the 12th bit -> COMMIT.
- COMMIT:
  - Exactly one cycle of imem_we or dmem_we with the registered address and data.
  - frame_cnt increments in the same cycle.
  - Next state is DRAIN.
  - Write latency: 1 cycle after the last data bit is sampled.
- DRAIN:
  - Wait for mode_in == 00, then go to IDLE.
  - Extra active cycles are ignored; this covers the driver's unsent trailing frame bit.
  - Back-to-back frames therefore require at least one idle cycle between them.
- Abort in PRE or SHIFT:
  - mode_in goes to 00 or changes to a different load mode -> set frame_err, no write, go to IDLE.
  - A new mode in that same cycle is not accepted; it is taken on the following cycle from IDLE.
- RUN:
  - run_out = 1 while mode_in == 11 and halt_in == 0.
  - done_out = 1 combinationally while in RUN with halt_in == 1; run_out = 0 in that case.
  - mode_in != 11 -> run_out and done_out drop in the same cycle; go to IDLE.
  - Load modes are not accepted directly from RUN; the driver returns to 00 first. A direct 11 -> 01 transition passes through IDLE (one cycle) and is then accepted.
- wr_addr and wr_data hold their last committed values between strobes.
- imem_we and dmem_we are never asserted together.
- frame_err clears only on rst.
- rst asserted mid-frame: the frame is discarded with no strobe and no frame_err.

Decomposition:
- Shared package: mode encoding constants (MODE_IDLE = 2'b00, MODE_LDI = 2'b01, MODE_LDD = 2'b10, MODE_RUN = 2'b11), FRAME_BITS, and the loader state enum typedef.
- The driver is expected to import the same mode constants.
- One natural sub-module, spi_frame_shifter: 12-bit LSB-first shift register with bit counter and full flag.
- The FSM and write-port logic stay in the top.

Test Plan:
- Instruction frame, mode 01 for 14 cycles, bits addr = 4'h3, data = 8'hA5 sent LSB first after 2 preamble cycles -> one imem_we pulse with wr_addr = 3, wr_data = A5; frame_cnt = 1; dmem_we stays 0.
- 16 back-to-back register frames, addr 0..F, data = addr ^ 8'h5A, 1 idle cycle between frames -> 16 dmem_we pulses with matching address/data; frame_cnt = 16; frame_err = 0.
- Truncation: mode 10 drops to 00 after 7 data bits -> no write strobe; frame_err = 1; a following valid frame commits normally and frame_err stays 1.
- Run handshake: mode 11 with halt_in = 0 -> run_out = 1; raise halt_in -> done_out = 1 and run_out = 0 in the same cycle; mode 00 -> done_out = 0.
- Mode change mid-frame: 01 switches to 10 after 5 bits -> frame_err = 1, no write; the next 10 frame (addr 9, data 8'h3C) writes dmem only.
- Reset during SHIFT after 6 bits -> all outputs 0, no strobe, frame_err = 0; a following full frame commits correctly.
